dm9000a_bus_sequencer: RTL
==========================

Name: dm9000a_bus_sequencer

Overview:
Executes one arbitrated Ethernet command at a time on the DM9000A host bus. It takes the command stream produced by the Ethernet controller arbitrator (start, type, addr, write data, post-command delay code) and generates the CMD/CS_N/IOR_N/IOW_N strobes and the data-bus drive. Index and data phases, strobe widths and post-command settling delays are handled here. Read data and a completion pulse are returned to the granted requester.

Parameters:
SETUP_CYCLES, 1, cycles that address/CMD/data are stable before the strobe falls (>=1)
STROBE_CYCLES, 2, IOR_N/IOW_N low width in cycles (>=1)
STD_DELAY_CYCLES, 4, post-command wait for delay code 1
LONG_DELAY_CYCLES, 200, post-command wait for delay codes 2 and 3
DELAY_W, 8, width of the delay counter; must hold LONG_DELAY_CYCLES

Ports:
Clock  in  1  system clock
Reset  in  1  synchronous, active-high reset
start_command_in  in  1  command request, sampled only while ready_out=1
command_type_in  in  2  0=reg write, 1=reg read, 2=data-port write, 3=data-port read
addr_in  in  8  DM9000A register index (unused for types 2/3)
dataw_in  in  16  write data
post_command_delay_in  in  3  0=none, 1=std, 2=long, 3..7=long
ready_out  out  1  idle, can accept a command
done_out  out  1  one-cycle completion pulse
datar_out  out  16  last read result
enet_cmd_out  out  1  0=index phase, 1=data phase
enet_cs_n_out  out  1  chip select, active low
enet_ior_n_out  out  1  read strobe, active low
enet_iow_n_out  out  1  write strobe, active low
enet_data_out  out  16  bus drive value
enet_data_oe_out  out  1  tristate enable for enet_data_out
enet_data_in  in  16  bus sample

Behaviour:
- Reset (synchronous, active-high): state IDLE. Outputs: ready_out=1, done_out=0, datar_out=0, cs_n=1, ior_n=1, iow_n=1, cmd=0, data_oe=0, data_out=0. A reset mid-command aborts it on the next edge with strobes released and no done pulse.
- States: IDLE, IDX_SETUP, IDX_STROBE, IDX_HOLD, DAT_SETUP, DAT_STROBE, DAT_HOLD, POST_DELAY, DONE.
- IDLE: ready_out=1. When start_command_in=1, latch type, addr, data and delay. Types 0/1 go to IDX_SETUP; types 2/3 go to DAT_SETUP. Start is ignored in every other state.
- Index phase: cmd=0, cs_n=0, oe=1, data_out={8'h00,addr}. Timing is SETUP_CYCLES, then STROBE_CYCLES with iow_n=0, then 1 hold cycle with strobe high and data still driven.
- Data phase: cmd=1, cs_n=0. Same setup/strobe/hold timing. For writes: oe=1, data_out=latched data, iow_n strobes. For reads: oe=0, ior_n strobes, and enet_data_in is captured into datar_out on the last strobe cycle's closing edge.
- After DAT_HOLD: go to POST_DELAY if the delay is nonzero, otherwise to DONE. POST_DELAY holds cs_n=1, oe=0 for N cycles.
- DONE: lasts 1 cycle with done_out=1, then returns to IDLE.
- Default latency (count from the accepting edge E0):
  - Reg access: done high during E8..E9.
  - Data-port access: done high during E4..E5.
  - Std delay adds 4 cycles.
- ior_n and iow_n are never low simultaneously, and neither is low while cs_n=1.
- datar_out changes only on read capture.
- Back-to-back commands: next start is accepted at the first IDLE edge, so there is a minimum of 1 idle cycle between commands.

Optional Feature:
Macro DM9000A_SEQ_STATS_EN.
- With the macro defined: adds outputs rd_count_out[15:0] and wr_count_out[15:0]. Each increments at DONE of a read-type or write-type command respectively. Both wrap at 16'hFFFF->0 and clear on Reset.
- Without the macro: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package dm9000a_pkg:
  - command type encodings (CMD_REG_WR=0, CMD_REG_RD=1, CMD_DAT_WR=2, CMD_DAT_RD=3)
  - delay codes (NO_DELAY=0, STD_DELAY=1, LONG_DELAY=2)
  - sequencer state encoding
- One natural sub-module: seq_cycle_timer, a loadable down-counter with a terminal-count flag. It is reused for the setup, strobe and post-delay intervals.

Test Plan:
- Reg write addr=8'h1F, data=16'h0001, delay 0 -> cmd=0 with data 16'h001F and iow_n low 2 cycles, then cmd=1 with 16'h0001 and iow_n low 2 cycles; done at E8; datar unchanged.
- Reg read addr=8'h28, bus returns 16'h0A46 in the data phase -> datar_out=16'h0A46 with done at E8; oe=0 throughout the data phase.
- Data-port write 16'hBEEF with delay 1 -> no index phase, done at E8 (4+4); cs_n high during the 4 delay cycles.
- Start asserted during DAT_STROBE and while done is high -> ignored; only one command executes; ready_out=0 until IDLE.
- Reset asserted in IDX_STROBE -> next edge has cs_n=1, iow_n=1, oe=0, ready_out=1, and no done pulse.
- With DM9000A_SEQ_STATS_EN defined: 3 reads and 2 writes -> rd_count_out=3, wr_count_out=2.

Source files
------------

// File: rtl/dm9000a_bus_sequencer_pkg.sv
// dm9000a_pkg: shared encodings for the DM9000A bus sequencer.
//   - command type encodings driven by the Ethernet controller arbitrator
//   - post-command delay codes
//   - sequencer state encoding
//   - small decode helpers for command types and delay codes
package dm9000a_pkg;

  localparam logic [1:0] CMD_REG_WR = 2'd0;
  localparam logic [1:0] CMD_REG_RD = 2'd1;
  localparam logic [1:0] CMD_DAT_WR = 2'd2;
  localparam logic [1:0] CMD_DAT_RD = 2'd3;

  localparam logic [2:0] NO_DELAY   = 3'd0;
  localparam logic [2:0] STD_DELAY  = 3'd1;
  localparam logic [2:0] LONG_DELAY = 3'd2;

  localparam logic [3:0] ST_IDLE       = 4'd0;
  localparam logic [3:0] ST_IDX_SETUP  = 4'd1;
  localparam logic [3:0] ST_IDX_STROBE = 4'd2;
  localparam logic [3:0] ST_IDX_HOLD   = 4'd3;
  localparam logic [3:0] ST_DAT_SETUP  = 4'd4;
  localparam logic [3:0] ST_DAT_STROBE = 4'd5;
  localparam logic [3:0] ST_DAT_HOLD   = 4'd6;
  localparam logic [3:0] ST_POST_DELAY = 4'd7;
  localparam logic [3:0] ST_DONE       = 4'd8;

  function automatic logic cmd_is_read(input logic [1:0] t);
    return (t == CMD_REG_RD) || (t == CMD_DAT_RD);
  endfunction

  // Register accesses need an index phase; data-port accesses do not.
  function automatic logic cmd_has_index(input logic [1:0] t);
    return (t == CMD_REG_WR) || (t == CMD_REG_RD);
  endfunction

  // Codes 2..7 all select the long settling delay.
  function automatic logic delay_is_long(input logic [2:0] d);
    return d >= LONG_DELAY;
  endfunction

endpackage

// File: rtl/dm9000a_bus_sequencer_if.sv
// dm9000a_bus_sequencer_if: command stream from the arbitrator plus the
// DM9000A host-bus pins.
//   master : arbitrator/bus side (drives commands and enet_data_in)
//   slave  : the sequencer (drives strobes, bus data and responses)
interface dm9000a_bus_sequencer_if;
  logic        start_command_in;
  logic [1:0]  command_type_in;
  logic [7:0]  addr_in;
  logic [15:0] dataw_in;
  logic [2:0]  post_command_delay_in;
  logic        ready_out;
  logic        done_out;
  logic [15:0] datar_out;
  logic        enet_cmd_out;
  logic        enet_cs_n_out;
  logic        enet_ior_n_out;
  logic        enet_iow_n_out;
  logic [15:0] enet_data_out;
  logic        enet_data_oe_out;
  logic [15:0] enet_data_in;

  modport master (
    output start_command_in, command_type_in, addr_in, dataw_in,
           post_command_delay_in, enet_data_in,
    input  ready_out, done_out, datar_out, enet_cmd_out, enet_cs_n_out,
           enet_ior_n_out, enet_iow_n_out, enet_data_out, enet_data_oe_out
  );

  modport slave (
    input  start_command_in, command_type_in, addr_in, dataw_in,
           post_command_delay_in, enet_data_in,
    output ready_out, done_out, datar_out, enet_cmd_out, enet_cs_n_out,
           enet_ior_n_out, enet_iow_n_out, enet_data_out, enet_data_oe_out
  );
endinterface

// File: rtl/dm9000a_bus_sequencer_timer.sv
// seq_cycle_timer: loadable down-counter with terminal-count flag.
//   Clock, Reset : clock, synchronous active-high reset (count -> 0)
//   load         : load load_value this cycle
//   load_value   : interval length minus one
//   tc           : count has reached zero
// Loading N-1 on entry to a state gives a state that lasts N cycles when
// the state exits on tc.
module seq_cycle_timer #(
  parameter int unsigned W = 8
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge Clock) begin
    if (Reset)
      count <= '0;
    else if (load)
      count <= load_value;
    else if (count != '0)
      count <= count - W'(1);
  end

  assign tc = (count == '0);

endmodule

// File: rtl/dm9000a_bus_sequencer.sv
// dm9000a_bus_sequencer: runs one arbitrated command at a time on the
// DM9000A host bus (index phase, data phase, optional settling delay).
//   Clock, Reset : clock, synchronous active-high reset
//   bus (slave)  : command stream in, ready/done/datar out, DM9000A pins
//   rd_count_out, wr_count_out : completed read/write command counters,
//                  present only when DM9000A_SEQ_STATS_EN is defined
module dm9000a_bus_sequencer
  import dm9000a_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES      = 1,
  parameter int unsigned STROBE_CYCLES     = 2,
  parameter int unsigned STD_DELAY_CYCLES  = 4,
  parameter int unsigned LONG_DELAY_CYCLES = 200,
  parameter int unsigned DELAY_W           = 8
) (
  input logic Clock,
  input logic Reset,
  dm9000a_bus_sequencer_if.slave bus
`ifdef DM9000A_SEQ_STATS_EN
  ,
  output logic [15:0] rd_count_out,
  output logic [15:0] wr_count_out
`endif
);

  localparam logic [DELAY_W-1:0] SETUP_LD  = DELAY_W'(SETUP_CYCLES - 1);
  localparam logic [DELAY_W-1:0] STROBE_LD = DELAY_W'(STROBE_CYCLES - 1);
  localparam logic [DELAY_W-1:0] STD_LD    = DELAY_W'(STD_DELAY_CYCLES - 1);
  localparam logic [DELAY_W-1:0] LONG_LD   = DELAY_W'(LONG_DELAY_CYCLES - 1);

  logic [3:0]         state, state_nx;
  logic [1:0]         type_q;
  logic [7:0]         addr_q;
  logic [15:0]        data_q;
  logic [2:0]         delay_q;
  logic [15:0]        datar_q;
  logic               tmr_load, tmr_tc;
  logic [DELAY_W-1:0] tmr_value;
  logic               is_read, idx_phase, dat_phase, accept;

  seq_cycle_timer #(.W(DELAY_W)) u_timer (
    .Clock      (Clock),
    .Reset      (Reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .tc         (tmr_tc)
  );

  assign accept  = (state == ST_IDLE) && bus.start_command_in;
  assign is_read = cmd_is_read(type_q);

  // The timer is loaded on the transition edge into each timed state.
  always_comb begin
    state_nx  = state;
    tmr_load  = 1'b0;
    tmr_value = '0;
    case (state)
      ST_IDLE:
        if (bus.start_command_in) begin
          tmr_load  = 1'b1;
          tmr_value = SETUP_LD;
          state_nx  = cmd_has_index(bus.command_type_in) ? ST_IDX_SETUP : ST_DAT_SETUP;
        end
      ST_IDX_SETUP:
        if (tmr_tc) begin
          tmr_load  = 1'b1;
          tmr_value = STROBE_LD;
          state_nx  = ST_IDX_STROBE;
        end
      ST_IDX_STROBE:
        if (tmr_tc) state_nx = ST_IDX_HOLD;
      ST_IDX_HOLD: begin
        tmr_load  = 1'b1;
        tmr_value = SETUP_LD;
        state_nx  = ST_DAT_SETUP;
      end
      ST_DAT_SETUP:
        if (tmr_tc) begin
          tmr_load  = 1'b1;
          tmr_value = STROBE_LD;
          state_nx  = ST_DAT_STROBE;
        end
      ST_DAT_STROBE:
        if (tmr_tc) state_nx = ST_DAT_HOLD;
      ST_DAT_HOLD:
        if (delay_q == NO_DELAY) begin
          state_nx = ST_DONE;
        end else begin
          tmr_load  = 1'b1;
          tmr_value = delay_is_long(delay_q) ? LONG_LD : STD_LD;
          state_nx  = ST_POST_DELAY;
        end
      ST_POST_DELAY:
        if (tmr_tc) state_nx = ST_DONE;
      ST_DONE:
        state_nx = ST_IDLE;
      default:
        state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= ST_IDLE;
      type_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      delay_q <= '0;
      datar_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        type_q  <= bus.command_type_in;
        addr_q  <= bus.addr_in;
        data_q  <= bus.dataw_in;
        delay_q <= bus.post_command_delay_in;
      end
      // Capture on the closing edge of the last strobe cycle.
      if ((state == ST_DAT_STROBE) && tmr_tc && is_read)
        datar_q <= bus.enet_data_in;
    end
  end

  assign idx_phase = (state == ST_IDX_SETUP) || (state == ST_IDX_STROBE) ||
                     (state == ST_IDX_HOLD);
  assign dat_phase = (state == ST_DAT_SETUP) || (state == ST_DAT_STROBE) ||
                     (state == ST_DAT_HOLD);

  always_comb begin
    bus.ready_out        = (state == ST_IDLE);
    bus.done_out         = (state == ST_DONE);
    bus.datar_out        = datar_q;
    bus.enet_cmd_out     = dat_phase;
    bus.enet_cs_n_out    = !(idx_phase || dat_phase);
    bus.enet_iow_n_out   = !((state == ST_IDX_STROBE) ||
                             ((state == ST_DAT_STROBE) && !is_read));
    bus.enet_ior_n_out   = !((state == ST_DAT_STROBE) && is_read);
    bus.enet_data_oe_out = idx_phase || (dat_phase && !is_read);
    bus.enet_data_out    = '0;
    if (idx_phase)
      bus.enet_data_out = {8'h00, addr_q};
    else if (dat_phase && !is_read)
      bus.enet_data_out = data_q;
  end

`ifdef DM9000A_SEQ_STATS_EN
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rd_count_out <= '0;
      wr_count_out <= '0;
    end else if (state == ST_DONE) begin
      if (is_read) rd_count_out <= rd_count_out + 16'd1;
      else         wr_count_out <= wr_count_out + 16'd1;
    end
  end
`endif

endmodule
